// File: rtl/gate_sweep_pkg.sv
// Shared types and helpers for the gate sweep checker: FSM state encoding,
// gate bit positions inside the 7-bit gate vector, and a popcount helper.
package gate_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int G_NOT     = 0;
    localparam int G_AND     = 1;
    localparam int G_OR      = 2;
    localparam int G_NAND    = 3;
    localparam int G_NOR     = 4;
    localparam int G_XOR     = 5;
    localparam int G_XNOR    = 6;
    localparam int NUM_GATES = 7;

    // Number of set bits in a 7-bit gate vector (0..7).
    function automatic logic [2:0] popcount7(input logic [0:6] v);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < NUM_GATES; i++) begin
            cnt = cnt + {2'b00, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gate_sweep_checker_golden.sv
// Combinational truth table of the 7-output two-input gate block.
// Bit positions follow the gate index constants in gate_sweep_pkg.
module gate_golden_model
    import gate_sweep_pkg::*;
(
    input  logic       a,
    input  logic       b,
    output logic [0:6] golden
);

    // Expected value of every gate for the present {a,b}.
    always_comb begin
        golden         = 7'b0000000;
        golden[G_NOT]  = ~a;
        golden[G_AND]  = a & b;
        golden[G_OR]   = a | b;
        golden[G_NAND] = ~(a & b);
        golden[G_NOR]  = ~(a | b);
        golden[G_XOR]  = a ^ b;
        golden[G_XNOR] = ~(a ^ b);
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// Self-running stimulus/response checker for the 7-output gate block.
// Walks {a,b} through 00,01,10,11 for SWEEPS passes, waits SETTLE_CYCLES
// after each drive, compares y_in to the golden table and accumulates
// per-gate sticky failures and a saturating mismatch count.
// Optional feature macro: GATE_SWEEP_FIRST_FAIL_EN adds capture of the
// first failing vector and its y_in value.
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int SWEEPS        = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a_out,
    output logic             b_out,
    input  logic [0:6]       y_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [0:6]       fail_mask,
    output logic [ERR_W-1:0] err_count
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    ,
    output logic [1:0]       first_fail_ab,
    output logic [0:6]       first_fail_y,
    output logic             first_fail_vld
`endif
);

    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0]       SWEEP_LAST  = 8'(SWEEPS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    state_t           state_r;
    state_t           next_state_s;
    logic [1:0]       vec_r;
    logic [7:0]       sweep_r;
    logic [3:0]       settle_r;
    logic [0:6]       golden_s;
    logic [0:6]       mism_s;
    logic [2:0]       pc_s;
    logic [ERR_W:0]   err_sum_s;
    logic [ERR_W-1:0] err_next_s;
    logic             accept_s;
    logic             run_end_s;

    gate_golden_model u_golden (
        .a      (a_out),
        .b      (b_out),
        .golden (golden_s)
    );

    // Per-gate mismatch; X/Z on y_in never matches a known golden value.
    always_comb begin
        mism_s = 7'b0000000;
        for (int i = 0; i < NUM_GATES; i++) begin
            if (y_in[i] !== golden_s[i]) begin
                mism_s[i] = 1'b1;
            end else begin
                mism_s[i] = 1'b0;
            end
        end
    end

    // Saturating accumulation of this sample's mismatch bits.
    always_comb begin
        pc_s       = popcount7(mism_s);
        err_sum_s  = {1'b0, err_count} + {{(ERR_W-2){1'b0}}, pc_s};
        err_next_s = ERR_MAX;
        if (err_sum_s[ERR_W]) begin
            err_next_s = ERR_MAX;
        end else begin
            err_next_s = err_sum_s[ERR_W-1:0];
        end
    end

    // Start is honoured only when no run is in progress.
    always_comb begin
        accept_s  = start && ((state_r == IDLE) || (state_r == DONE));
        run_end_s = (vec_r == 2'd3) && (sweep_r == SWEEP_LAST);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) next_state_s = DRIVE;
                else          next_state_s = IDLE;
            end
            DRIVE: begin
                next_state_s = SETTLE;
            end
            SETTLE: begin
                if (settle_r == 4'd0) next_state_s = SAMPLE;
                else                  next_state_s = SETTLE;
            end
            SAMPLE: begin
                if (run_end_s) next_state_s = DONE;
                else           next_state_s = DRIVE;
            end
            DONE: begin
                if (accept_s) next_state_s = DRIVE;
                else          next_state_s = DONE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Datapath: stimulus registers, counters and run statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out          <= 1'b0;
            b_out          <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_mask      <= 7'b0000000;
            err_count      <= {ERR_W{1'b0}};
            vec_r          <= 2'd0;
            sweep_r        <= 8'd0;
            settle_r       <= 4'd0;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
            first_fail_ab  <= 2'b00;
            first_fail_y   <= 7'b0000000;
            first_fail_vld <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s) begin
                        fail_mask      <= 7'b0000000;
                        err_count      <= {ERR_W{1'b0}};
                        vec_r          <= 2'd0;
                        sweep_r        <= 8'd0;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
                        first_fail_ab  <= 2'b00;
                        first_fail_y   <= 7'b0000000;
                        first_fail_vld <= 1'b0;
`endif
                    end
                end
                DRIVE: begin
                    {a_out, b_out} <= vec_r;
                    settle_r       <= SETTLE_LOAD;
                end
                SETTLE: begin
                    if (settle_r != 4'd0) begin
                        settle_r <= settle_r - 4'd1;
                    end
                end
                SAMPLE: begin
                    fail_mask <= fail_mask | mism_s;
                    err_count <= err_next_s;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
                    if (!first_fail_vld && (mism_s != 7'b0000000)) begin
                        first_fail_ab  <= {a_out, b_out};
                        first_fail_y   <= y_in;
                        first_fail_vld <= 1'b1;
                    end
`endif
                    if (vec_r == 2'd3) begin
                        vec_r   <= 2'd0;
                        sweep_r <= sweep_r + 8'd1;
                        if (run_end_s) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                            pass <= ((fail_mask | mism_s) == 7'b0000000);
                        end
                    end else begin
                        vec_r <= vec_r + 2'd1;
                    end
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Self-checking bench for gate_sweep_checker. Two instances with different
// parameters share clock and reset; each is fed by a behavioural gate block
// with injectable stuck-at and flip faults. Expected statistics come from a
// run-level model that walks sweeps and vectors with plain arithmetic.
module tb_gate_sweep_checker;

    localparam int S0 = 1;
    localparam int W0 = 1;
    localparam int E0 = 8;
    localparam int S1 = 2;
    localparam int W1 = 3;
    localparam int E1 = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start0, start1;
    logic          a0, b0, a1, b1;
    logic [0:6]    y0, y1;
    logic          busy0, done0, pass0, busy1, done1, pass1;
    logic [0:6]    fm0, fm1;
    logic [E0-1:0] ec0;
    logic [E1-1:0] ec1;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    logic [1:0]    ffab0, ffab1;
    logic [0:6]    ffy0, ffy1;
    logic          ffv0, ffv1;
`endif

    int checks = 0;
    int errors = 0;

    logic [0:6] flip [2][4];
    logic [0:6] frc0 [2];
    logic [0:6] frc1 [2];

    always #5 clk = ~clk;

    gate_sweep_checker #(.SETTLE_CYCLES(S0), .SWEEPS(W0), .ERR_W(E0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .a_out(a0), .b_out(b0), .y_in(y0),
        .busy(busy0), .done(done0), .pass(pass0), .fail_mask(fm0), .err_count(ec0)
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        , .first_fail_ab(ffab0), .first_fail_y(ffy0), .first_fail_vld(ffv0)
`endif
    );

    gate_sweep_checker #(.SETTLE_CYCLES(S1), .SWEEPS(W1), .ERR_W(E1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1), .y_in(y1),
        .busy(busy1), .done(done1), .pass(pass1), .fail_mask(fm1), .err_count(ec1)
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        , .first_fail_ab(ffab1), .first_fail_y(ffy1), .first_fail_vld(ffv1)
`endif
    );

    // Gate behaviour from the count of ones among the two inputs.
    function automatic logic [0:6] ref_gates(input logic a, input logic b);
        int ia, ib, s;
        logic [0:6] r;
        ia = a ? 1 : 0;
        ib = b ? 1 : 0;
        s  = ia + ib;
        r[0] = (ia == 0);
        r[1] = (s == 2);
        r[2] = (s >= 1);
        r[3] = (s != 2);
        r[4] = (s == 0);
        r[5] = (s == 1);
        r[6] = (s != 1);
        return r;
    endfunction

    // Faulty gate blocks seen by each instance.
    always_comb y0 = ((ref_gates(a0, b0) ^ flip[0][{a0, b0}]) & ~frc0[0]) | frc1[0];
    always_comb y1 = ((ref_gates(a1, b1) ^ flip[1][{a1, b1}]) & ~frc0[1]) | frc1[1];

    task automatic clear_faults();
        for (int s = 0; s < 2; s++) begin
            frc0[s] = 7'b0000000;
            frc1[s] = 7'b0000000;
            for (int v = 0; v < 4; v++) flip[s][v] = 7'b0000000;
        end
    endtask

    // Run-level expectation: sticky mask, saturated count, and run length.
    task automatic model(input int sel, output logic [0:6] fm, output int err, output int len);
        int sweeps, settle, maxe;
        logic a, b;
        logic [0:6] t, y;
        sweeps = (sel == 0) ? W0 : W1;
        settle = (sel == 0) ? S0 : S1;
        maxe   = (sel == 0) ? (1 << E0) - 1 : (1 << E1) - 1;
        fm  = 7'b0000000;
        err = 0;
        for (int s = 0; s < sweeps; s++) begin
            for (int v = 0; v < 4; v++) begin
                a = (v / 2) == 1;
                b = (v % 2) == 1;
                t = ref_gates(a, b);
                y = ((t ^ flip[sel][v]) & ~frc0[sel]) | frc1[sel];
                err = err + $countones(y ^ t);
                fm  = fm | (y ^ t);
            end
        end
        if (err > maxe) err = maxe;
        len = sweeps * 4 * (settle + 2);
    endtask

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done0 : done1;
    endfunction

    function automatic int get_err(input int sel);
        return (sel == 0) ? int'(ec0) : int'(ec1);
    endfunction

    // Pulse start, capture status just after acceptance, then count cycles to done.
    task automatic run(input int sel, output int cycles, output logic acc_busy,
                       output logic acc_done, output logic acc_pass,
                       output logic [0:6] acc_fm, output int acc_err);
        @(negedge clk);
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start0   = 1'b0;
        start1   = 1'b0;
        acc_busy = (sel == 0) ? busy0 : busy1;
        acc_done = get_done(sel);
        acc_pass = (sel == 0) ? pass0 : pass1;
        acc_fm   = (sel == 0) ? fm0 : fm1;
        acc_err  = get_err(sel);
        cycles   = 0;
        while (!get_done(sel) && cycles < 400) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        clear_faults();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy0, done0, pass0, a0, b0, fm0, ec0} !== 20'd0) begin
            errors++; $display("FAIL reset_dut0: got %b want all zero", {busy0, done0, pass0, a0, b0, fm0, ec0});
        end
        checks++;
        if ({busy1, done1, pass1, a1, b1, fm1, ec1} !== 16'd0) begin
            errors++; $display("FAIL reset_dut1: got %b want all zero", {busy1, done1, pass1, a1, b1, fm1, ec1});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_golden();
        int c, ae, ee, len; logic ab, ad, ap; logic [0:6] af, ef;
        clear_faults();
        run(0, c, ab, ad, ap, af, ae);
        model(0, ef, ee, len);
        checks++;
        if (c !== 12 || len !== 12) begin errors++; $display("FAIL golden_len0: got %0d want 12", c); end
        checks++;
        if (ab !== 1'b1 || ad !== 1'b0) begin errors++; $display("FAIL golden_accept: busy=%b done=%b want 1 0", ab, ad); end
        checks++;
        if ({pass0, busy0, fm0} !== {1'b1, 1'b0, 7'b0000000} || ec0 !== 8'd0) begin
            errors++; $display("FAIL golden_stats0: pass=%b busy=%b fm=%b err=%0d want 1 0 0 0", pass0, busy0, fm0, ec0);
        end
        checks++;
        if ({a0, b0} !== 2'b11) begin errors++; $display("FAIL done_holds_ab: got %b want 11", {a0, b0}); end
        run(1, c, ab, ad, ap, af, ae);
        model(1, ef, ee, len);
        checks++;
        if (c !== len || !pass1 || fm1 !== 7'b0000000 || ec1 !== 4'd0) begin
            errors++; $display("FAIL golden_dut1: len=%0d pass=%b fm=%b err=%0d want %0d 1 0 0", c, pass1, fm1, ec1, len);
        end
    endtask

    task automatic test_stuck_xor();
        int c, ae, ee, len; logic ab, ad, ap; logic [0:6] af, ef;
        clear_faults();
        frc0[0][5] = 1'b1;
        run(0, c, ab, ad, ap, af, ae);
        model(0, ef, ee, len);
        checks++;
        if (fm0 !== 7'b0000010 || ec0 !== 8'd2 || pass0 !== 1'b0 || ef !== 7'b0000010 || ee !== 2) begin
            errors++; $display("FAIL xor_stuck0: fm=%b err=%0d pass=%b want 0000010 2 0", fm0, ec0, pass0);
        end
    endtask

    task automatic test_all_zero();
        int c, ae, ee, len; logic ab, ad, ap; logic [0:6] af, ef;
        clear_faults();
        frc0[0] = 7'b1111111;
        frc0[1] = 7'b1111111;
        run(0, c, ab, ad, ap, af, ae);
        checks++;
        if (fm0 !== 7'b1111111 || ec0 !== 8'd14) begin
            errors++; $display("FAIL zero_dut0: fm=%b err=%0d want 1111111 14", fm0, ec0);
        end
        run(1, c, ab, ad, ap, af, ae);
        model(1, ef, ee, len);
        checks++;
        if (fm1 !== 7'b1111111 || ec1 !== 4'd15 || ee !== 15 || c !== 48) begin
            errors++; $display("FAIL zero_dut1_sat: fm=%b err=%0d len=%0d want 1111111 15 48", fm1, ec1, c);
        end
    endtask

    task automatic test_random();
        int c, ae, ee, len, sel; logic ab, ad, ap; logic [0:6] af, ef;
        for (int i = 0; i < 10; i++) begin
            clear_faults();
            sel = i % 2;
            for (int v = 0; v < 4; v++) begin
                if ($urandom_range(0, 2) != 0) flip[sel][v] = 7'($urandom_range(0, 127));
            end
            if ($urandom_range(0, 3) == 0) frc1[sel] = 7'($urandom_range(0, 127));
            run(sel, c, ab, ad, ap, af, ae);
            model(sel, ef, ee, len);
            checks++;
            if (c !== len) begin errors++; $display("FAIL rand_len[%0d]: got %0d want %0d", i, c, len); end
            checks++;
            if (((sel == 0) ? fm0 : fm1) !== ef || get_err(sel) !== ee ||
                ((sel == 0) ? pass0 : pass1) !== (ef == 7'b0000000)) begin
                errors++; $display("FAIL rand_stats[%0d]: fm=%b err=%0d want %b %0d", i,
                                   (sel == 0) ? fm0 : fm1, get_err(sel), ef, ee);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int c, ae; logic ab, ad, ap; logic [0:6] af;
        clear_faults();
        frc0[0] = 7'b1111111;
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if (ec0 !== 8'd8 || {a0, b0} !== 2'b10 || busy0 !== 1'b1) begin
            errors++; $display("FAIL midrun_state: err=%0d ab=%b busy=%b want 8 10 1", ec0, {a0, b0}, busy0);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy0, done0, pass0, a0, b0, fm0, ec0} !== 20'd0) begin
            errors++; $display("FAIL async_reset: got %b want all zero", {busy0, done0, pass0, a0, b0, fm0, ec0});
        end
        @(negedge clk); rst = 1'b0;
        clear_faults();
        run(0, c, ab, ad, ap, af, ae);
        checks++;
        if (c !== 12 || pass0 !== 1'b1 || ec0 !== 8'd0) begin
            errors++; $display("FAIL after_reset_run: len=%0d pass=%b err=%0d want 12 1 0", c, pass0, ec0);
        end
    endtask

    task automatic test_busy_start();
        int c, ae, ee, len; logic ab, ad, ap; logic [0:6] af, ef;
        clear_faults();
        flip[0][1] = 7'b0100001;
        flip[0][3] = 7'b0000100;
        model(0, ef, ee, len);
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        c = 0;
        while (!done0 && c < 400) begin
            @(posedge clk); #1; c++;
            if (c == 4) start0 = 1'b1; else start0 = 1'b0;
        end
        start0 = 1'b0;
        checks++;
        if (c !== 12 || fm0 !== ef || int'(ec0) !== ee) begin
            errors++; $display("FAIL busy_start_ignored: len=%0d fm=%b err=%0d want 12 %b %0d", c, fm0, ec0, ef, ee);
        end
        clear_faults();
        run(0, c, ab, ad, ap, af, ae);
        checks++;
        if (ad !== 1'b0 || ap !== 1'b0 || af !== 7'b0000000 || ae !== 0 || ab !== 1'b1) begin
            errors++; $display("FAIL restart_clear: done=%b pass=%b fm=%b err=%0d busy=%b want 0 0 0 0 1", ad, ap, af, ae, ab);
        end
        checks++;
        if (c !== 12 || pass0 !== 1'b1) begin
            errors++; $display("FAIL restart_run: len=%0d pass=%b want 12 1", c, pass0);
        end
    endtask

`ifdef GATE_SWEEP_FIRST_FAIL_EN
    task automatic test_first_fail();
        int c, ae; logic ab, ad, ap; logic [0:6] af;
        clear_faults();
        frc1[0][1] = 1'b1;
        run(0, c, ab, ad, ap, af, ae);
        checks++;
        if (ffv0 !== 1'b1 || ffab0 !== 2'b00 || ffy0 !== 7'b1101101) begin
            errors++; $display("FAIL first_fail: vld=%b ab=%b y=%b want 1 00 1101101", ffv0, ffab0, ffy0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_golden();
        test_stuck_xor();
        test_all_zero();
        test_random();
        test_reset_mid_run();
        test_busy_start();
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        test_first_fail();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
